// File: rtl/pipe_mem_stage_pkg.sv
// Shared ISA encodings and pipeline bundle types for the rv32 MEM stage.
package pipe_mem_stage_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_BUS      = 2'd2,
        FAULT_TIMEOUT  = 2'd3
    } mem_fault_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic       valid;
        logic       mem_en;
        logic       wb_en;
        logic [6:0] opcode;
        logic [2:0] func3;
    } ctrl_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } reg_t;

    typedef struct packed {
        ctrl_t ctrl;
        reg_t  rs;
        reg_t  rd;
    } ex_mem_t;

    typedef struct packed {
        ctrl_t ctrl;
        reg_t  rd;
    } mem_wb_t;

endpackage

// File: rtl/pipe_mem_stage_lane_align.sv
// Byte-lane steering: store enables/replicated data, load extraction/extension
// and the alignment check for byte, half and word accesses.
module mem_lane_align
    import pipe_mem_stage_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
        half_sel   = rdata[{addr_lo[1], 4'b0000} +: 16];
        be         = 4'b0000;
        wdata      = 32'h0;
        load_data  = rdata;
        // func3[1:0] encodes access size identically for loads and stores
        misaligned = ((func3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((func3[1:0] == 2'b10) && (addr_lo != 2'b00));

        case (func3)
            F3_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_SH: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            F3_SW: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: ;
        endcase

        case (func3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {24'h0, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {16'h0, half_sel};
            F3_LW:   load_data = rdata;
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// rv32 MEM stage: single-outstanding req/ack data-memory access with stall,
// flush/kill handling, timeout abort and fault reporting.
module pipe_mem_stage
    import pipe_mem_stage_pkg::*;
#(
    parameter int AckTimeout   = 255,
    parameter int TimeoutWidth = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  ex_mem_t     ex_mem_i,
    input  logic        flush_i,
    output logic        stall_o,
    output mem_wb_t     mem_wb_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_err_i,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    localparam logic [TimeoutWidth-1:0] TimeoutLast = TimeoutWidth'(AckTimeout - 1);

    mem_state_e            state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [TimeoutWidth-1:0] cnt_q, cnt_d;
    logic                  kill_q, kill_d;
    logic                  fault_q, fault_d;
    mem_fault_e            cause_q, cause_d;
    mem_wb_t               mem_wb_q, mem_wb_d;

    logic        is_load, is_store, is_mem_op, timeout;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_load;
    logic        lane_misaligned;
    logic        unused_rs_addr;

    assign unused_rs_addr = ^ex_mem_i.rs.addr;

    mem_lane_align u_lane_align (
        .func3      (ex_mem_i.ctrl.func3),
        .addr_lo    (ex_mem_i.rd.data[1:0]),
        .store_data (ex_mem_i.rs.data),
        .rdata      (dmem_rdata_i),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load),
        .misaligned (lane_misaligned)
    );

    assign is_load   = ex_mem_i.ctrl.opcode == OPC_LOAD;
    assign is_store  = ex_mem_i.ctrl.opcode == OPC_STORE;
    assign is_mem_op = ex_mem_i.ctrl.valid & ex_mem_i.ctrl.mem_en & (is_load | is_store);
    assign timeout   = (state_q == ST_REQ) && !dmem_ack_i && (cnt_q == TimeoutLast);

    // Upstream holds ex_mem_i stable during REQ, so it still describes the
    // in-flight access on the ack/abort cycle and is used to build the result.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        kill_d   = kill_q;
        fault_d  = 1'b0;
        cause_d  = cause_q;
        mem_wb_d = '0;
        stall_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    mem_wb_d = '0;
                end else if (is_mem_op && lane_misaligned) begin
                    mem_wb_d.ctrl       = ex_mem_i.ctrl;
                    mem_wb_d.ctrl.wb_en = 1'b0;
                    mem_wb_d.rd         = ex_mem_i.rd;
                    fault_d             = 1'b1;
                    cause_d             = FAULT_MISALIGN;
                end else if (is_mem_op) begin
                    stall_o = 1'b1;
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {ex_mem_i.rd.data[31:2], 2'b00};
                    be_d    = lane_be;
                    wdata_d = lane_wdata;
                    cnt_d   = '0;
                    kill_d  = 1'b0;
                end else begin
                    mem_wb_d.ctrl = ex_mem_i.ctrl;
                    mem_wb_d.rd   = ex_mem_i.rd;
                end
            end
            ST_REQ: begin
                stall_o = !(dmem_ack_i || timeout);
                if (dmem_ack_i || timeout) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    kill_d  = 1'b0;
                    if (!(kill_q || flush_i)) begin
                        mem_wb_d.ctrl = ex_mem_i.ctrl;
                        mem_wb_d.rd   = ex_mem_i.rd;
                        if (timeout) begin
                            mem_wb_d.ctrl.wb_en = 1'b0;
                            fault_d             = 1'b1;
                            cause_d             = FAULT_TIMEOUT;
                        end else if (dmem_err_i) begin
                            mem_wb_d.ctrl.wb_en = 1'b0;
                            fault_d             = 1'b1;
                            cause_d             = FAULT_BUS;
                        end else if (we_q) begin
                            mem_wb_d.ctrl.wb_en = 1'b0;
                        end else begin
                            mem_wb_d.rd.data = lane_load;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (flush_i) begin
                        kill_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            cnt_q    <= '0;
            kill_q   <= 1'b0;
            fault_q  <= 1'b0;
            cause_q  <= FAULT_NONE;
            mem_wb_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            kill_q   <= kill_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign mem_wb_o      = mem_wb_q;
    assign dmem_req_o    = req_q;
    assign dmem_we_o     = we_q;
    assign dmem_addr_o   = addr_q;
    assign dmem_be_o     = be_q;
    assign dmem_wdata_o  = wdata_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;

endmodule

// File: doc/pipe_mem_stage.md
Name: pipe_mem_stage

Overview:
MEM stage of the rv32 pipeline. It consumes the EX→MEM bundle (ex_mem_t), performs loads and stores on a single-outstanding data-memory req/ack bus, and produces the registered MEM→WB bundle (mem_wb_t). While an access is in flight it stalls EX and upstream. It also reports misaligned accesses, bus errors and bus timeouts.

Parameters:
AckTimeout, 255, max cycles in REQ without dmem_ack_i before the access is aborted (range 1..65535)
TimeoutWidth, 16, width of the timeout counter

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
ex_mem_i  in  ex_mem_t  EX→MEM bundle; held stable by upstream while stall_o=1
flush_i  in  1  kill the current MEM-stage instruction
stall_o  out  1  hold EX and earlier stages this cycle
mem_wb_o  out  mem_wb_t  registered MEM→WB bundle
dmem_req_o  out  1  bus request, held until ack or abort
dmem_we_o  out  1  1=store, 0=load
dmem_addr_o  out  32  word-aligned byte address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_ack_i  in  1  access complete; rdata/err valid this cycle
dmem_rdata_i  in  32  load word
dmem_err_i  in  1  bus error, qualified by ack
fault_o  out  1  one-cycle pulse on misalign, bus error or timeout
fault_cause_o  out  2  0 none, 1 misaligned, 2 bus error, 3 timeout; held until next fault

Behaviour:
- Reset (async, rst=1): state=IDLE; all dmem_* outputs=0; stall_o=0; mem_wb_o=0 (ctrl.valid=0); fault_o=0; fault_cause_o=0; timeout counter=0.
- Field use: address=ex_mem_i.rd.data; store data=ex_mem_i.rs.data; destination=ex_mem_i.rd.addr.
- mem op = ctrl.valid & ctrl.mem_en & opcode ∈ {LOAD 0000011, STORE 0100011}.
- Non-mem valid instruction: stall_o=0; mem_wb_o gets ctrl and rd unchanged at the next edge (latency 1).
- Alignment check: LH/LHU/SH need addr[0]=0. LW/SW need addr[1:0]=0. Byte ops are always aligned.
- Misaligned op: no bus cycle. Next edge: mem_wb_o.ctrl.valid=1, wb_en=0; fault_o=1, cause=1.
- FSM states: IDLE and REQ.
- IDLE with an aligned mem op and flush_i=0: stall_o=1; next state REQ; dmem_req_o=1 registered with addr/be/wdata/we; counter cleared.
- REQ: dmem_req_o and the address/data outputs stay stable. stall_o=~(dmem_ack_i|timeout).
  - Ack cycle: dmem_req_o=0 next edge; state→IDLE. mem_wb_o loaded with the result: load → rd.data=extended rdata; store → wb_en=0.
  - dmem_err_i with ack: result bubble-equivalent (valid=1, wb_en=0); fault_o=1, cause=2.
- Timeout: counter increments each REQ cycle without ack. When counter==AckTimeout-1 without ack: abort, drop dmem_req_o, state→IDLE, stall_o=0 that cycle, output valid=1/wb_en=0, fault cause=3. A late ack in IDLE is ignored.
- Any cycle with stall_o=1 loads mem_wb_o with a bubble (ctrl.valid=0).
- Load extension, with lane a=addr[1:0]:
  - LB: sign-extend rdata[8a+7:8a]; LBU: zero-extend.
  - LH/LHU: rdata[16a'+15:16a'] with a'=addr[1], sign- or zero-extended.
  - LW: full word.
- Store enables/data:
  - SB: be=0001<<a, wdata={4{rs[7:0]}}.
  - SH: be=0011<<a, wdata={2{rs[15:0]}}.
  - SW: be=1111, wdata=rs.
- Flush:
  - In IDLE: no request is issued; output bubble; stall_o=0.
  - In REQ: sets kill_q. The bus access still completes (stores are not aborted). On ack or timeout, output is a bubble and no fault is raised. kill_q clears on return to IDLE.
- Ack and flush in the same REQ cycle: ack completes the access; the result is killed.
- Reset mid-REQ: dmem_req_o drops immediately (async). The bus slave must tolerate an abandoned request.

Decomposition:
- rv32_isa gets the LOAD/STORE opcodes and the func3 encodings (LB..LHU, SB..SW).
- pipeline_types gets mem_fault_e (2-bit cause) and mem_state_e {IDLE, REQ}.
- One combinational sub-module, mem_lane_align: func3 + addr[1:0] + rs data + rdata → be, wdata, extended load data, misaligned flag.

Test Plan:
- LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF → req held 3 cycles, stall_o=1 until the ack cycle; mem_wb_o.rd.data=0xDEADBEEF, wb_en=1, one cycle after ack.
- LB addr 0x103 rdata 0x80123456 → rd.data=0xFFFFFF80. LBU same → 0x00000080. LH addr 0x102 → 0xFFFF8012.
- SB addr 0x201, rs=0x000000A5 → be=0010, wdata=0xA5A5A5A5, we=1; mem_wb_o wb_en=0.
- SW addr 0x302 → no dmem_req_o; fault_o pulse, cause=1; stall_o never asserted.
- LW with no ack, AckTimeout=4 → req drops after 4 REQ cycles, cause=3, stall releases. A late ack is ignored.
- flush_i during REQ of a store, ack 2 cycles later → store completes on the bus, mem_wb_o bubble, no fault. Also: async reset mid-REQ → dmem_req_o=0 within the reset assertion, state IDLE.
